mem_arbiter: RTL and testbench

//  Shares the single-port memory bus between instruction fetch (IF) and the data accesses

---
 rtl/memarb_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memarb_pkg.sv
// Shared types for the memory bus arbiter: FSM states, bus owner encoding
// and the byte-enable pattern used for instruction fetches.
package memarb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        FETCH,
        DATA
    } owner_t;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and MEM-stage
// data accesses. Data wins by default; after STARVE_MAX back-to-back data
// grants with a fetch waiting, the fetch is granted. One transaction in
// flight at a time.
//
// Optional feature: define MEMARB_TIMEOUT_EN to add a WAIT-state timeout
// (TIMEOUT cycles) that completes the transaction with if_err/d_err.
//
// state | meaning
// IDLE  | no transaction; arbitrate and register the grant
// ISSUE | bus_req high with owner's fields until bus_rdy
// WAIT  | request accepted; waiting for bus_rvalid
// RESP  | owner's ack pulse, captured word on owner's rdata
module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int STARVE_MAX = 4
`ifdef MEMARB_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_rdy,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
`ifdef MEMARB_TIMEOUT_EN
    , output logic      if_err,
    output logic        d_err
`endif
);

    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state;
    arb_state_t       next_state;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_data;
    logic             grant_fetch;

`ifdef MEMARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0] wait_cnt;
    logic       err_q;
    logic       timed_out;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state, grant decision and bus/ack outputs
    always_comb begin
        next_state  = state;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_be      = '0;
        if_ack      = 1'b0;
        d_ack       = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
        timed_out   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (d_req && !(if_req && starve_cnt == STARVE_LIM)) begin
                    grant_data = 1'b1;
                    next_state = ISSUE;
                end else if (if_req) begin
                    grant_fetch = 1'b1;
                    next_state  = ISSUE;
                end
            end
            ISSUE: begin
                bus_req = 1'b1;
                if (owner == DATA) begin
                    bus_we    = d_we;
                    bus_addr  = d_addr;
                    bus_wdata = d_wdata;
                    bus_be    = d_be;
                end else begin
                    bus_addr = if_addr;
                    bus_be   = BE_FULL;
                end
                if (bus_rdy) next_state = WAIT;
            end
            WAIT: begin
                if (bus_rvalid) begin
                    next_state = RESP;
                end
`ifdef MEMARB_TIMEOUT_EN
                else if (wait_cnt == TIMEOUT_CNT) begin
                    timed_out  = 1'b1;
                    next_state = RESP;
                end
`endif
            end
            RESP: begin
                if_ack     = (owner == FETCH);
                d_ack      = (owner == DATA);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Owner, starvation counter and per-requester read data capture
    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner      <= NONE;
            starve_cnt <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if (grant_data) begin
                owner <= DATA;
                if (if_req)
                    starve_cnt <= (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 1'b1;
                else
                    starve_cnt <= '0;
            end else if (grant_fetch) begin
                owner      <= FETCH;
                starve_cnt <= '0;
            end else if (state == RESP) begin
                owner <= NONE;
            end

            if (state == WAIT && bus_rvalid) begin
                if (owner == FETCH)     if_rdata <= bus_rdata;
                else if (owner == DATA) d_rdata  <= bus_rdata;
            end
`ifdef MEMARB_TIMEOUT_EN
            else if (timed_out) begin
                if (owner == FETCH)     if_rdata <= '0;
                else if (owner == DATA) d_rdata  <= '0;
            end
`endif
        end
    end

`ifdef MEMARB_TIMEOUT_EN
    // WAIT cycle counter (cleared on entry) and sticky error flag for RESP
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE && bus_rdy) wait_cnt <= '0;
            else if (state == WAIT)        wait_cnt <= wait_cnt + 8'd1;

            if (timed_out)          err_q <= 1'b1;
            else if (state == RESP) err_q <= 1'b0;
        end
    end

    assign if_err = (state == RESP) && (owner == FETCH) && err_q;
    assign d_err  = (state == RESP) && (owner == DATA) && err_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus requests and acks are
// queued as stimulus is driven; a negedge monitor acts as the memory and
// pops/compares on bus acceptance and on every ack.
// Define MEMARB_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rdy;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
`ifdef MEMARB_TIMEOUT_EN
    logic        if_err;
    logic        d_err;
`endif

    always #5 clk = ~clk;

`ifdef MEMARB_TIMEOUT_EN
    mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
`else
    mem_arbiter #(.STARVE_MAX(4)) dut (
`endif
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_rdy(bus_rdy), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
`ifdef MEMARB_TIMEOUT_EN
        , .if_err(if_err), .d_err(d_err)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic        fetch;
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    req_t exp_req[$];
    ack_t exp_ack[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_accept = 0;

    logic        rsp_enable = 1'b1;
    int          rsp_delay  = 0;
    logic        rsp_pending = 1'b0;
    int          rsp_wait   = 0;
    logic [31:0] rsp_data   = '0;
    logic        rv_prev    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
        req_t r;
        r.we = we; r.addr = a; r.wdata = wd; r.be = be;
        exp_req.push_back(r);
    endtask

    task automatic push_ack(input logic fetch, input logic [31:0] rd, input logic err);
        ack_t k;
        k.fetch = fetch; k.rdata = rd; k.err = err;
        exp_ack.push_back(k);
    endtask

    task automatic push_load(input logic [31:0] a);
        push_req(1'b0, a, 32'h0, 4'hF);
        push_ack(1'b0, mem_word(a), 1'b0);
    endtask

    task automatic push_fetch(input logic [31:0] a);
        push_req(1'b0, a, 32'h0, 4'hF);
        push_ack(1'b1, mem_word(a), 1'b0);
    endtask

    // Memory model and scoreboard: responds to accepted requests, checks acks
    always @(negedge clk) begin
        req_t r;
        ack_t k;
        rv_prev    = bus_rvalid;
        bus_rvalid = 1'b0;
        if (rsp_pending) begin
            if (rsp_wait == 0) begin
                bus_rvalid  = 1'b1;
                bus_rdata   = rsp_data;
                rsp_pending = 1'b0;
            end else begin
                rsp_wait--;
            end
        end
        if (rstn && bus_req && bus_rdy) begin
            n_accept++;
            if (exp_req.size() == 0) begin
                check("unexpected_bus_req", {32'h0, bus_addr}, 64'hFFFF_FFFF);
            end else begin
                r = exp_req.pop_front();
                check("bus_addr", {32'h0, bus_addr}, {32'h0, r.addr});
                check("bus_we_be", {59'h0, bus_we, bus_be}, {59'h0, r.we, r.be});
                check("bus_wdata", {32'h0, bus_wdata}, {32'h0, r.wdata});
            end
            rsp_pending = rsp_enable;
            rsp_wait    = rsp_delay;
            rsp_data    = bus_we ? 32'h0 : mem_word(bus_addr);
        end
        if (if_ack || d_ack) begin
            if (exp_ack.size() == 0) begin
                check("unexpected_ack", {62'h0, if_ack, d_ack}, 64'h0);
            end else begin
                k = exp_ack.pop_front();
                check("ack_owner", {62'h0, if_ack, d_ack}, k.fetch ? 64'h2 : 64'h1);
                check("ack_rdata", {32'h0, (k.fetch ? if_rdata : d_rdata)}, {32'h0, k.rdata});
                if (!k.err) check("ack_after_rvalid", {63'h0, rv_prev}, 64'h1);
`ifdef MEMARB_TIMEOUT_EN
                check("err_flags", {62'h0, if_err, d_err},
                      k.err ? (k.fetch ? 64'h2 : 64'h1) : 64'h0);
`endif
            end
        end
    end

    task automatic wait_ack(input int budget, output int cyc, output logic gi, output logic gd);
        cyc = -1; gi = 1'b0; gd = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                cyc = i; gi = if_ack; gd = d_ack;
                return;
            end
        end
        check("ack_wait_expired", 64'h0, 64'h1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   cyc;
        int   di;
        int   acc0;
        logic gi, gd;

        rstn = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; bus_rdy = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) step();
        @(negedge clk);
        check("rst_outputs", {60'h0, bus_req, if_ack, d_ack, bus_we}, 64'h0);
        check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
        check("rst_bus_addr", {32'h0, bus_addr}, 64'h0);
        check("rst_starve", {61'h0, dut.starve_cnt}, 64'h0);
        step();
        rstn = 1'b1;
        step();

        // Fetch only: ack in the 4th cycle counting the request cycle
        push_fetch(32'h100);
        if_req = 1'b1; if_addr = 32'h100;
        wait_ack(20, cyc, gi, gd);
        check("t1_latency", 64'(cyc), 64'd4);
        check("t1_if_rdata", {32'h0, if_rdata}, 64'hDEADBEEF);
        step();
        if_req = 1'b0;
        step();
        check("t1_rdata_hold", {32'h0, if_rdata}, 64'hDEADBEEF);

        // Simultaneous: data first, fetch right after
        push_load(32'h2000);
        push_fetch(32'h200);
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF; d_wdata = '0;
        wait_ack(20, cyc, gi, gd);
        check("t2_data_first", {63'h0, gd}, 64'h1);
        step();
        d_req = 1'b0;
        wait_ack(20, cyc, gi, gd);
        check("t2_fetch_second", {63'h0, gi}, 64'h1);
        step();
        if_req = 1'b0;
        step();

        // Starvation: four data grants, then the fetch, then data again
        for (int i = 0; i < 4; i++) push_load(32'h3000 + 32'(4 * i));
        push_fetch(32'h400);
        push_load(32'h3010);
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_addr = 32'h3000;
        di = 0;
        for (int k = 0; k < 6; k++) begin
            wait_ack(20, cyc, gi, gd);
            if (gd) begin
                di++;
                if (di == 4) check("t3_starve_sat", {61'h0, dut.starve_cnt}, 64'd4);
            end
            if (gi) begin
                check("t3_fetch_after_4", 64'(di), 64'd4);
                check("t3_starve_clr", {61'h0, dut.starve_cnt}, 64'd0);
            end
            step();
            if (gd) begin
                if (di < 5) d_addr = 32'h3000 + 32'(4 * di);
                else        d_req = 1'b0;
            end
            if (gi) if_req = 1'b0;
        end
        step();

        // Backpressure: bus_rdy low for 3 ISSUE cycles
        push_load(32'h2400);
        acc0 = n_accept;
        bus_rdy = 1'b0;
        d_req = 1'b1; d_addr = 32'h2400;
        for (int i = 0; i < 10 && !bus_req; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("t4_req_held", {31'h0, bus_req, bus_addr}, {31'h0, 1'b1, 32'h2400});
            check("t4_be_held", {60'h0, bus_be}, 64'hF);
            step();
            if (i == 2) bus_rdy = 1'b1;
            @(negedge clk);
        end
        check("t4_req_4th", {31'h0, bus_req, bus_addr}, {31'h0, 1'b1, 32'h2400});
        wait_ack(20, cyc, gi, gd);
        check("t4_single_accept", 64'(n_accept - acc0), 64'd1);
        step();
        d_req = 1'b0;
        step();

        // Store with partial byte enables
        push_req(1'b1, 32'h4000, 32'h00AB00AB, 4'b0011);
        push_ack(1'b0, 32'h0, 1'b0);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4000; d_wdata = 32'h00AB00AB; d_be = 4'b0011;
        wait_ack(20, cyc, gi, gd);
        check("t5_store_latency", 64'(cyc), 64'd4);
        step();
        d_req = 1'b0; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
        step();

        // Reset while in WAIT; the late response must be ignored
        push_req(1'b0, 32'h5000, 32'h0, 4'hF);
        rsp_delay = 3;
        acc0 = n_accept;
        d_req = 1'b1; d_addr = 32'h5000;
        for (int i = 0; i < 10 && n_accept == acc0; i++) @(negedge clk);
        check("t6_accepted", 64'(n_accept - acc0), 64'd1);
        step();
        rstn = 1'b0; d_req = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        check("t6_req_dropped", {63'h0, bus_req}, 64'h0);
        for (int i = 0; i < 6; i++) begin
            check("t6_no_ack", {62'h0, if_ack, d_ack}, 64'h0);
            @(negedge clk);
        end
        check("t6_rdata_ignored", {32'h0, d_rdata}, 64'h0);
        rsp_delay = 0;
        step();

`ifdef MEMARB_TIMEOUT_EN
        // No response: timeout completes the load with d_err and zero data
        push_req(1'b0, 32'h6000, 32'h0, 4'hF);
        push_ack(1'b0, 32'h0, 1'b1);
        rsp_enable = 1'b0;
        d_req = 1'b1; d_addr = 32'h6000;
        wait_ack(40, cyc, gi, gd);
        check("t7_timeout_ack", {63'h0, gd}, 64'h1);
        step();
        d_req = 1'b0;
        rsp_enable = 1'b1;
        step();
`endif

        repeat (3) step();
        check("queues_drained", 64'(exp_req.size() + exp_ack.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
